divider_seq: RTL and testbench

- Iterative signed/unsigned integer divider: the inverse operation of the team's pipelined multiplier.
- Restoring algorithm, one quotient bit per cycle.
- Start/done handshake, since latency is long and fixed, unlike the multiplier's enable-gated pipeline.
- Used by datapaths that need quotient/remainder without a wide combinational divider.

---
 rtl/divider_seq_pkg.sv | 10 +
 rtl/divider_seq_step.sv | 23 ++
 rtl/divider_seq.sv | 129 ++++++++++++
 tb/tb_divider_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/divider_seq_pkg.sv
// Shared types for the sequential restoring divider.
package divider_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

endpackage

// File: rtl/divider_seq_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module divider_seq_step #(
  parameter int WIDTH_D = 16
) (
  input  logic [WIDTH_D:0]   rem_in,
  input  logic               bit_in,
  input  logic [WIDTH_D-1:0] div,
  output logic [WIDTH_D:0]   rem_out,
  output logic               q_bit
);

  logic [WIDTH_D+1:0] shifted;
  logic [WIDTH_D+1:0] diff;

  // One spare bit above the partial remainder makes the borrow visible as the diff MSB.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, div};
    q_bit   = ~diff[WIDTH_D+1];
    rem_out = q_bit ? diff[WIDTH_D:0] : shifted[WIDTH_D:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle, start/done handshake.
module divider_seq #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH_N-1:0] num,
  input  logic [WIDTH_D-1:0] den,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quo,
  output logic [WIDTH_D-1:0] rem,
  output logic               div_by_zero
);

  import divider_seq_pkg::*;

  localparam int CNT_W = $clog2(WIDTH_N + 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH_N-1:0] dvd;
  logic [WIDTH_D:0]   prem;
  logic [WIDTH_D:0]   prem_next;
  logic [WIDTH_D-1:0] dmag;
  logic [WIDTH_D-1:0] num_lo;
  logic               sign_q;
  logic               sign_r;
  logic               dbz;
  logic               q_bit;

  logic               num_neg;
  logic               den_neg;
  logic [WIDTH_N-1:0] num_abs;
  logic [WIDTH_D-1:0] den_abs;
  logic [WIDTH_D-1:0] r_mag;

  always_comb begin
    num_neg = is_signed & num[WIDTH_N-1];
    den_neg = is_signed & den[WIDTH_D-1];
    num_abs = num_neg ? -num : num;
    den_abs = den_neg ? -den : den;
    r_mag   = prem[WIDTH_D-1:0];
  end

  divider_seq_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .rem_in  (prem),
    .bit_in  (dvd[WIDTH_N-1]),
    .div     (dmag),
    .rem_out (prem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == CNT_W'(1)) next_state = SIGN;
      SIGN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // dvd shifts dividend bits out at the top while quotient bits fill in at the bottom.
  // The most-negative / -1 case needs no special path: |num|/1 negated wraps back to num.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd         <= '0;
      prem        <= '0;
      dmag        <= '0;
      num_lo      <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd    <= num_abs;
            prem   <= '0;
            dmag   <= den_abs;
            num_lo <= num[WIDTH_D-1:0];
            sign_q <= num_neg ^ den_neg;
            sign_r <= num_neg;
            dbz    <= (den == '0);
            cnt    <= CNT_W'(WIDTH_N);
          end
        end
        CALC: begin
          prem <= prem_next;
          dvd  <= {dvd[WIDTH_N-2:0], q_bit};
          cnt  <= cnt - CNT_W'(1);
        end
        SIGN: begin
          done        <= 1'b1;
          div_by_zero <= dbz;
          if (dbz) begin
            quo <= '1;
            rem <= num_lo;
          end else begin
            quo <= sign_q ? -dvd : dvd;
            rem <= sign_r ? -r_mag : r_mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed and randomised self-checking bench for divider_seq at 16/16 bits.
module tb_divider_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int total_count = 0;
  int pass_count  = 0;

  divider_seq #(
    .WIDTH_N (W),
    .WIDTH_D (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .num         (num),
    .den         (den),
    .busy        (busy),
    .done        (done),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drive a one-cycle start; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic s, input logic [W-1:0] n, input logic [W-1:0] d);
    @(negedge clk);
    is_signed = s;
    num       = n;
    den       = d;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges since the accepting edge until done is seen; bounded.
  task automatic waitDone(input int base, output int lat);
    lat = base;
    while (lat < base + 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
  endtask

  task automatic doOp(input string tag, input logic s, input logic [W-1:0] n, input logic [W-1:0] d,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int lat;
    applyStimulus(s, n, d);
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    waitDone(0, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd17);
    checkOutput({tag, " quo"}, 32'(quo), 32'(eq));
    checkOutput({tag, " rem"}, 32'(rem), 32'(er));
    checkOutput({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    int lat;
    int done_seen;
    logic [31:0] tq;
    logic [31:0] tr;
    int sn;
    int sd;
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    logic rs;

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    num       = '0;
    den       = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset quo", 32'(quo), 32'd0);
    checkOutput("reset rem", 32'(rem), 32'd0);
    checkOutput("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    doOp("u 100/7", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("done pulse width", 32'(done), 32'd0);
    checkOutput("result hold quo", 32'(quo), 32'd14);

    doOp("s -100/7", 1'b1, 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0);
    doOp("s 100/-7", 1'b1, 16'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0);
    doOp("u 100/0", 1'b0, 16'd100, 16'd0, 16'hFFFF, 16'd100, 1'b1);
    doOp("s 100/0", 1'b1, 16'd100, 16'd0, 16'hFFFF, 16'd100, 1'b1);
    doOp("s ovf", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    doOp("u 8000/FFFF", 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    doOp("s -1/-32768", 1'b1, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFF, 1'b0);

    // Start while busy must be ignored.
    applyStimulus(1'b0, 16'd100, 16'd7);
    repeat (4) @(posedge clk);
    #1;
    num   = 16'd1000;
    den   = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ignored start busy", 32'(busy), 32'd1);
    waitDone(5, lat);
    checkOutput("ignored start latency", 32'(lat), 32'd17);
    checkOutput("ignored start quo", 32'(quo), 32'd14);
    checkOutput("ignored start rem", 32'(rem), 32'd2);

    // Back-to-back: start issued in the done cycle.
    doOp("b2b first", 1'b0, 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    doOp("b2b second", 1'b0, 16'hFFFF, 16'd16, 16'h0FFF, 16'd15, 1'b0);

    // Reset mid-CALC aborts with no done.
    applyStimulus(1'b0, 16'd5000, 16'd9);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort quo", 32'(quo), 32'd0);
    checkOutput("abort rem", 32'(rem), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort no done", 32'(done_seen), 32'd0);
    doOp("after abort", 1'b0, 16'd5000, 16'd9, 16'd555, 16'd5, 1'b0);

    // Random vectors against a behavioural reference.
    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom_range(0, 1));
      rn = W'($urandom);
      rd = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom >> $urandom_range(0, 15));
      if (rd == '0) begin
        tq = 32'hFFFF;
        tr = 32'(rn);
      end else if (rs) begin
        sn = $signed(rn);
        sd = $signed(rd);
        if (sn == -32768 && sd == -1) begin
          tq = 32'h8000;
          tr = 32'h0;
        end else begin
          tq = 32'(sn / sd);
          tr = 32'(sn % sd);
        end
      end else begin
        tq = 32'(rn) / 32'(rd);
        tr = 32'(rn) % 32'(rd);
      end
      applyStimulus(rs, rn, rd);
      waitDone(0, lat);
      checkOutput("rand latency", 32'(lat), 32'd17);
      checkOutput("rand quo", 32'(quo), {16'h0, tq[15:0]});
      checkOutput("rand rem", 32'(rem), {16'h0, tr[15:0]});
      checkOutput("rand dbz", 32'(div_by_zero), 32'(rd == '0));
    end

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
